// File: rtl/bus_trace_buffer.sv
// Passive trace buffer for processor bus write events (memWr/regWr).
// Circular store with a pop port, sticky overflow flag and a selectable drop/overwrite policy.
module bus_trace_buffer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CAPTURE_REG = 1,
    parameter int WRAP_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      memWr,
    input  logic                      regWr,
    input  logic [ADDR_W-1:0]         direc,
    input  logic [DATA_W-1:0]         datoOut,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [ADDR_W-1:0]         rd_direc,
    output logic [DATA_W-1:0]         rd_dato,
    output logic [1:0]                rd_kind,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow
);

    localparam int   PTR_W     = $clog2(DEPTH);
    localparam int   CNT_W     = PTR_W + 1;
    localparam logic L_CAP_REG = (CAPTURE_REG != 0);
    localparam logic L_WRAP    = (WRAP_MODE != 0);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [1:0]        r_mem_kind [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_direc;
    logic [DATA_W-1:0] r_rd_dato;
    logic [1:0]        r_rd_kind;

    logic              w_cap;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovwr;
    logic              w_drop;
    logic [1:0]        w_kind;

    assign w_cap   = en & (memWr | (L_CAP_REG & regWr));
    assign w_kind  = {regWr & L_CAP_REG, memWr};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // clr wins over everything, so every same-cycle push/pop is masked by it
    assign w_pop   = rd_en & ~w_empty & ~clr;
    assign w_push  = w_cap & ~clr & (~w_full | w_pop | L_WRAP);
    assign w_ovwr  = w_cap & ~clr & w_full & ~w_pop & L_WRAP;
    assign w_drop  = w_cap & ~clr & w_full & ~w_pop & ~L_WRAP;

    // Storage has no reset: its contents only matter between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= direc;
            r_mem_data[r_wr_ptr] <= datoOut;
            r_mem_kind[r_wr_ptr] <= w_kind;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            // An overwrite discards the oldest entry, so the read side advances too
            if (w_pop | w_ovwr)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push & ~w_pop & ~w_ovwr)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop & ~w_push)
                r_count <= r_count - CNT_W'(1);
            if (w_ovwr | w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Pop port: rd_* only change on a real pop and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_direc <= '0;
            r_rd_dato  <= '0;
            r_rd_kind  <= '0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_direc <= r_mem_addr[r_rd_ptr];
                r_rd_dato  <= r_mem_data[r_rd_ptr];
                r_rd_kind  <= r_mem_kind[r_rd_ptr];
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_direc = r_rd_direc;
    assign rd_dato  = r_rd_dato;
    assign rd_kind  = r_rd_kind;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer: a vector table on the default build plus
// hand sequences on two DEPTH=4 builds (drop/no-regWr and overwrite).
module tb_bus_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, clr = 1'b0, memWr = 1'b0, regWr = 1'b0, rd_en = 1'b0;
    logic [31:0] direc = '0, datoOut = '0;

    // default build: 32/32, DEPTH 16, regWr captured, drop policy
    logic        m_vld, m_empty, m_full, m_ovf;
    logic [31:0] m_a, m_d;
    logic [1:0]  m_k;
    logic [4:0]  m_cnt;

    // DEPTH 4, memWr only, drop policy
    logic        a_vld, a_empty, a_full, a_ovf;
    logic [7:0]  a_a, a_d;
    logic [1:0]  a_k;
    logic [2:0]  a_cnt;

    // DEPTH 4, regWr captured, overwrite policy
    logic        b_vld, b_empty, b_full, b_ovf;
    logic [7:0]  b_a, b_d;
    logic [1:0]  b_k;
    logic [2:0]  b_cnt;

    bus_trace_buffer u_main (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .memWr(memWr), .regWr(regWr),
        .direc(direc), .datoOut(datoOut), .rd_en(rd_en),
        .rd_valid(m_vld), .rd_direc(m_a), .rd_dato(m_d), .rd_kind(m_k),
        .count(m_cnt), .empty(m_empty), .full(m_full), .overflow(m_ovf)
    );

    bus_trace_buffer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CAPTURE_REG(0), .WRAP_MODE(0)) u_drop (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .memWr(memWr), .regWr(regWr),
        .direc(direc[7:0]), .datoOut(datoOut[7:0]), .rd_en(rd_en),
        .rd_valid(a_vld), .rd_direc(a_a), .rd_dato(a_d), .rd_kind(a_k),
        .count(a_cnt), .empty(a_empty), .full(a_full), .overflow(a_ovf)
    );

    bus_trace_buffer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CAPTURE_REG(1), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .memWr(memWr), .regWr(regWr),
        .direc(direc[7:0]), .datoOut(datoOut[7:0]), .rd_en(rd_en),
        .rd_valid(b_vld), .rd_direc(b_a), .rd_dato(b_d), .rd_kind(b_k),
        .count(b_cnt), .empty(b_empty), .full(b_full), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        en, clr, mw, rw, rd;
        logic [31:0] a, d;
        logic        ev;
        logic [31:0] ea, ed;
        logic [1:0]  ek;
        int          ec;
        logic        ee, ef, eo;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic mw, input logic rw, input logic rd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic ev, input logic [31:0] ea, input logic [31:0] ed, input logic [1:0] ek,
                       input int ec, input logic ee, input logic ef, input logic eo);
        vec_t v;
        v.en = e; v.clr = c; v.mw = mw; v.rw = rw; v.rd = rd; v.a = a; v.d = d;
        v.ev = ev; v.ea = ea; v.ed = ed; v.ek = ek; v.ec = ec; v.ee = ee; v.ef = ef; v.eo = eo;
        vt.push_back(v);
    endtask

    task automatic drive(input logic e, input logic c, input logic mw, input logic rw, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        en = e; clr = c; memWr = mw; regWr = rw; rd_en = rd; direc = a; datoOut = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        //   en clr mw rw rd  addr   data  | vld addr   data  kind cnt emp full ovf
        add(0, 0, 0, 0, 0, 32'h00, 32'h00, 0, 32'h00, 32'h00, 2'b00, 0, 1, 0, 0);
        add(1, 0, 1, 0, 0, 32'h10, 32'h11, 0, 32'h00, 32'h00, 2'b00, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 32'h14, 32'h22, 0, 32'h00, 32'h00, 2'b00, 2, 0, 0, 0);
        add(1, 0, 1, 0, 0, 32'h18, 32'h33, 0, 32'h00, 32'h00, 2'b00, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 1, 32'h10, 32'h11, 2'b01, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 1, 32'h14, 32'h22, 2'b01, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 1, 32'h18, 32'h33, 2'b01, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 0, 32'h00, 32'h00, 2'b00, 0, 1, 0, 0);
        add(1, 0, 1, 1, 0, 32'h20, 32'h44, 0, 32'h00, 32'h00, 2'b00, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 32'h30, 32'h55, 0, 32'h00, 32'h00, 2'b00, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 32'h24, 32'h66, 0, 32'h00, 32'h00, 2'b00, 2, 0, 0, 0);
        add(1, 0, 1, 0, 1, 32'h28, 32'h77, 1, 32'h20, 32'h44, 2'b11, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 1, 32'h24, 32'h66, 2'b10, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 1, 32'h28, 32'h77, 2'b01, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 32'h2C, 32'h88, 0, 32'h00, 32'h00, 2'b00, 1, 0, 0, 0);
        add(1, 1, 1, 0, 1, 32'h3C, 32'h99, 0, 32'h00, 32'h00, 2'b00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h00, 32'h00, 0, 32'h00, 32'h00, 2'b00, 0, 1, 0, 0);

        idle();
        #12 rst_n = 1'b1;
        cyc();
        chk("rst_count", 32'(m_cnt), 0);
        chk("rst_empty", 32'(m_empty), 1);
        chk("rst_vld", 32'(m_vld), 0);
        chk("rst_dato", m_d, 0);

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].clr, vt[i].mw, vt[i].rw, vt[i].rd, vt[i].a, vt[i].d);
            cyc();
            chk($sformatf("v%0d_vld", i), 32'(m_vld), 32'(vt[i].ev));
            chk($sformatf("v%0d_cnt", i), 32'(m_cnt), 32'(vt[i].ec));
            chk($sformatf("v%0d_empty", i), 32'(m_empty), 32'(vt[i].ee));
            chk($sformatf("v%0d_full", i), 32'(m_full), 32'(vt[i].ef));
            chk($sformatf("v%0d_ovf", i), 32'(m_ovf), 32'(vt[i].eo));
            if (vt[i].ev) begin
                chk($sformatf("v%0d_direc", i), m_a, vt[i].ea);
                chk($sformatf("v%0d_dato", i), m_d, vt[i].ed);
                chk($sformatf("v%0d_kind", i), 32'(m_k), 32'(vt[i].ek));
            end
        end

        // regWr-only event is ignored when regWr capture is off
        drive(0, 1, 0, 0, 0, 0, 0); cyc();
        drive(1, 0, 0, 1, 0, 32'h40, 32'h41); cyc();
        chk("noreg_cnt", 32'(a_cnt), 0);
        chk("noreg_empty", 32'(a_empty), 1);
        chk("reg_cnt", 32'(b_cnt), 1);

        // full + push + pop: both accepted, no overflow
        drive(0, 1, 0, 0, 0, 0, 0); cyc();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 1, 0, 0, 32'(k), 32'(k)); cyc();
        end
        chk("fill_full_a", 32'(a_full), 1);
        chk("fill_full_b", 32'(b_full), 1);
        drive(1, 0, 1, 0, 1, 32'h5, 32'h5); cyc();
        chk("pp_cnt_a", 32'(a_cnt), 4);
        chk("pp_ovf_a", 32'(a_ovf), 0);
        chk("pp_vld_a", 32'(a_vld), 1);
        chk("pp_dato_a", 32'(a_d), 1);
        chk("pp_cnt_b", 32'(b_cnt), 4);
        chk("pp_ovf_b", 32'(b_ovf), 0);
        chk("pp_dato_b", 32'(b_d), 1);
        // clr beats a same-cycle push + pop
        drive(1, 1, 1, 0, 1, 32'h6, 32'h6); cyc();
        chk("clr_cnt", 32'(a_cnt), 0);
        chk("clr_empty", 32'(a_empty), 1);
        chk("clr_vld", 32'(a_vld), 0);
        chk("clr_vld_b", 32'(b_vld), 0);
        chk("clr_hold_b", 32'(b_d), 1);

        // overflow: drop build keeps 1..4, overwrite build keeps 3..6
        for (int k = 1; k <= 6; k++) begin
            drive(1, 0, 1, 0, 0, 32'(k), 32'(k)); cyc();
            if (k == 4) begin
                chk("ovf4_a", 32'(a_ovf), 0);
                chk("ovf4_b", 32'(b_ovf), 0);
            end
        end
        chk("ovf_full_a", 32'(a_full), 1);
        chk("ovf_a", 32'(a_ovf), 1);
        chk("ovf_cnt_b", 32'(b_cnt), 4);
        chk("ovf_b", 32'(b_ovf), 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0); cyc();
            chk($sformatf("drop_pop%0d", k), 32'(a_d), 32'(k + 1));
            chk($sformatf("drop_adr%0d", k), 32'(a_a), 32'(k + 1));
            chk($sformatf("wrap_pop%0d", k), 32'(b_d), 32'(k + 3));
        end
        chk("drain_empty_b", 32'(b_empty), 1);

        // async reset mid-cycle while capturing, with rd_valid and overflow high
        drive(1, 0, 1, 0, 0, 32'h7, 32'h7);
        chk("pre_rst_vld", 32'(b_vld), 1);
        chk("pre_rst_ovf", 32'(b_ovf), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(b_empty), 1);
        chk("arst_cnt", 32'(b_cnt), 0);
        chk("arst_ovf", 32'(b_ovf), 0);
        chk("arst_vld", 32'(b_vld), 0);
        chk("arst_ovf_a", 32'(a_ovf), 0);
        chk("arst_dato", 32'(a_d), 0);
        cyc();
        chk("arst_hold_cnt", 32'(b_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
